// File: rtl/apb_if.sv
// APB bus bundle between a master and the apb_regfile slave.
interface apb_if #(
  parameter int AW = 12,
  parameter int DW = 32
) ();
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile.sv
// APB register file: NREG-1 byte-strobed R/W registers plus a read-only ID
// register at the top index, with a fixed number of wait states per transfer.
module apb_regfile #(
  parameter int              DW       = 32,
  parameter int              AW       = 12,
  parameter int              NREG     = 8,
  parameter int              WAIT_CYC = 0,
  parameter logic [DW-1:0]   RST_VAL  = {DW{1'b0}},
  parameter logic [63:0]     ID_VAL   = 64'h0000_0000_0A9B_0001
) (
  input  logic               pclk,
  input  logic               preset,
  apb_if.slave               bus,
  output logic [NREG*DW-1:0] reg_q,
  output logic [NREG-1:0]    reg_wr
);

  localparam int             SW       = DW / 8;
  localparam int             IW       = AW - 2;
  localparam logic [IW:0]    NREG_L   = (IW + 1)'(NREG);
  localparam logic [IW-1:0]  ID_IDX   = IW'(NREG - 1);
  localparam logic [DW-1:0]  ID_W     = ID_VAL[DW-1:0];
  localparam logic [3:0]     CNT_INIT = 4'((WAIT_CYC == 0) ? 0 : (WAIT_CYC - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_nxt_s;

  logic [AW-1:0]    addr_r;
  logic             write_r;
  logic [DW-1:0]    wdata_r;
  logic [SW-1:0]    strb_r;
  logic [DW-1:0]    regs_r [NREG-1];

  logic             take_s;
  logic [AW-1:0]    cap_addr_s;
  logic             cap_write_s;
  logic [IW-1:0]    idx_s;
  logic             valid_s;
  logic             is_id_s;
  logic             err_s;
  logic [DW-1:0]    rdata_s;
  logic             commit_s;
  logic [NREG-1:0]  wr_onehot_s;

  logic [DW-1:0]    prdata_nxt_s;
  logic             pready_nxt_s;
  logic             pslverr_nxt_s;
  logic [DW-1:0]    prdata_r;
  logic             pready_r;
  logic             pslverr_r;
  logic [NREG-1:0]  reg_wr_r;

  assign take_s = (state_r == ST_IDLE) && bus.psel && !bus.penable;

  // State register and wait-state counter.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; dropping psel during wait states abandons the transfer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          if (WAIT_CYC == 0) begin
            state_nxt_s = ST_RESP;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_INIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      ST_WAIT: begin
        if (!bus.psel) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Decode uses the live bus in the setup cycle so a zero-wait response can be registered.
  always_comb begin
    cap_addr_s  = take_s ? bus.paddr  : addr_r;
    cap_write_s = take_s ? bus.pwrite : write_r;
    idx_s       = cap_addr_s[AW-1:2];
    valid_s     = ({1'b0, idx_s} < NREG_L) && (cap_addr_s[1:0] == 2'b00);
    is_id_s     = (idx_s == ID_IDX);
    err_s       = !valid_s || (cap_write_s && is_id_s);
    rdata_s     = {DW{is_id_s}} & ID_W;
    for (int i = 0; i < NREG - 1; i++) begin
      rdata_s = rdata_s | ({DW{idx_s == IW'(i)}} & regs_r[i]);
    end
  end

  // Output and write-enable decode.
  always_comb begin
    pready_nxt_s  = (state_nxt_s == ST_RESP);
    pslverr_nxt_s = pready_nxt_s && err_s;
    prdata_nxt_s  = (pready_nxt_s && !err_s && !cap_write_s) ? rdata_s : {DW{1'b0}};
    commit_s      = (state_r == ST_RESP) && write_r && !err_s;
    wr_onehot_s   = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      wr_onehot_s[i] = commit_s && (idx_s == IW'(i));
    end
  end

  // Registered bus outputs, request capture and register file update.
  always_ff @(posedge pclk) begin
    if (preset) begin
      prdata_r  <= {DW{1'b0}};
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      reg_wr_r  <= {NREG{1'b0}};
      addr_r    <= {AW{1'b0}};
      write_r   <= 1'b0;
      wdata_r   <= {DW{1'b0}};
      strb_r    <= {SW{1'b0}};
      for (int i = 0; i < NREG - 1; i++) begin
        regs_r[i] <= RST_VAL;
      end
    end else begin
      prdata_r  <= prdata_nxt_s;
      pready_r  <= pready_nxt_s;
      pslverr_r <= pslverr_nxt_s;
      reg_wr_r  <= wr_onehot_s;
      if (take_s) begin
        addr_r  <= bus.paddr;
        write_r <= bus.pwrite;
        wdata_r <= bus.pwdata;
        strb_r  <= bus.pstrb;
      end
      for (int i = 0; i < NREG - 1; i++) begin
        for (int b = 0; b < SW; b++) begin
          if (wr_onehot_s[i] && strb_r[b]) begin
            regs_r[i][8*b +: 8] <= wdata_r[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.prdata  = prdata_r;
  assign bus.pready  = pready_r;
  assign bus.pslverr = pslverr_r;
  assign reg_wr      = reg_wr_r;

  for (genvar g = 0; g < NREG - 1; g++) begin : g_regq
    assign reg_q[g*DW +: DW] = regs_r[g];
  end
  assign reg_q[(NREG-1)*DW +: DW] = ID_W;

endmodule

// File: tb/tb_apb_regfile.sv
// Scoreboard bench for apb_regfile: three instances with 0, 3 and 5 wait states
// share the bus lines and are selected individually through their psel.
module tb_apb_regfile;

  typedef struct {
    int          d;
    logic [31:0] rdata;
    bit          chk_rd;
    bit          err;
  } exp_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [2:0]  sel = 3'b000;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = 12'h000;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;

  logic [2:0]   pready_v;
  logic [2:0]   pslverr_v;
  logic [31:0]  prdata_v [3];
  logic [255:0] regq_v [3];
  logic [7:0]   regwr_v [3];
  logic [255:0] regq0, regq1, regq2;
  logic [7:0]   regwr0, regwr1, regwr2;

  int   wc_v [3] = '{0, 3, 5};
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q [$];
  exp_t mon_e;

  localparam logic [255:0] ID_ONLY = {32'h0A9B_0001, 224'h0};

  apb_if #(.AW(12), .DW(32)) if0 ();
  apb_if #(.AW(12), .DW(32)) if1 ();
  apb_if #(.AW(12), .DW(32)) if2 ();

  assign if0.psel = sel[0];  assign if1.psel = sel[1];  assign if2.psel = sel[2];
  assign if0.penable = penable; assign if1.penable = penable; assign if2.penable = penable;
  assign if0.pwrite = pwrite; assign if1.pwrite = pwrite; assign if2.pwrite = pwrite;
  assign if0.paddr = paddr;   assign if1.paddr = paddr;   assign if2.paddr = paddr;
  assign if0.pwdata = pwdata; assign if1.pwdata = pwdata; assign if2.pwdata = pwdata;
  assign if0.pstrb = pstrb;   assign if1.pstrb = pstrb;   assign if2.pstrb = pstrb;

  assign pready_v  = {if2.pready, if1.pready, if0.pready};
  assign pslverr_v = {if2.pslverr, if1.pslverr, if0.pslverr};
  assign prdata_v[0] = if0.prdata; assign prdata_v[1] = if1.prdata; assign prdata_v[2] = if2.prdata;
  assign regq_v[0] = regq0; assign regq_v[1] = regq1; assign regq_v[2] = regq2;
  assign regwr_v[0] = regwr0; assign regwr_v[1] = regwr1; assign regwr_v[2] = regwr2;

  apb_regfile #(.WAIT_CYC(0)) u0 (.pclk(pclk), .preset(preset), .bus(if0), .reg_q(regq0), .reg_wr(regwr0));
  apb_regfile #(.WAIT_CYC(3)) u1 (.pclk(pclk), .preset(preset), .bus(if1), .reg_q(regq1), .reg_wr(regwr1));
  apb_regfile #(.WAIT_CYC(5)) u2 (.pclk(pclk), .preset(preset), .bus(if2), .reg_q(regq2), .reg_wr(regwr2));

  always #5 pclk = ~pclk;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every pready pops one expected response; otherwise outputs must be 0.
  always @(negedge pclk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (pready_v[d]) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pready: dut %0d raised pready, no response expected", d);
          end else begin
            mon_e = exp_q.pop_front();
            chk("resp_dut", 256'(d), 256'(mon_e.d));
            chk("pslverr", 256'(pslverr_v[d]), 256'(mon_e.err));
            if (mon_e.chk_rd) chk("prdata", 256'(prdata_v[d]), 256'(mon_e.rdata));
          end
        end else begin
          chk("idle_outputs", {pslverr_v[d], prdata_v[d]}, 256'h0);
        end
      end
    end
  end

  task automatic xfer(input int d, input bit wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_rd, input bit exp_err,
                      input logic [7:0] exp_wr);
    exp_t e;
    int   n;
    e.d = d; e.rdata = exp_rd; e.chk_rd = !wr; e.err = exp_err;
    exp_q.push_back(e);
    sel = 3'b000; sel[d] = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready_v[d] && n < 40) begin
      @(posedge pclk); #1;
      n++;
    end
    if (n >= 40) begin
      n_vec++; n_err++;
      $display("FAIL pready_timeout: dut %0d addr %h no pready within 40 cycles", d, addr);
      exp_q.delete();
    end else begin
      chk("latency", 256'(n), 256'(wc_v[d]));
    end
    @(posedge pclk); #1;
    sel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    chk("reg_wr", 256'(regwr_v[d]), 256'(exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    mon_en = 1'b1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready", 256'(pready_v[d]), 256'h0);
      chk("rst_reg_wr", 256'(regwr_v[d]), 256'h0);
      chk("rst_reg_q", regq_v[d], ID_ONLY);
    end

    // Zero-wait write/read, reg_wr pulse width.
    xfer(0, 1'b1, 12'h004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 8'h02);
    chk("reg_q_r1", 256'(regq_v[0][63:32]), 256'(32'hDEAD_BEEF));
    @(posedge pclk); #1;
    chk("reg_wr_one_cycle", 256'(regwr_v[0]), 256'h0);
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 8'h00);

    // Byte strobes, including an all-zero strobe that still pulses reg_wr.
    xfer(0, 1'b1, 12'h008, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 8'h04);
    xfer(0, 1'b1, 12'h008, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 8'h04);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 32'hFF22_FF44, 1'b0, 8'h00);
    xfer(0, 1'b1, 12'h00C, 32'h1234_5678, 4'h0, 32'h0, 1'b0, 8'h08);
    xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b0, 8'h00);

    // Error cases: ID write, out of range, misaligned.
    xfer(0, 1'b1, 12'h01C, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b1, 8'h00);
    xfer(0, 1'b1, 12'h020, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b1, 8'h00);
    xfer(0, 1'b1, 12'h006, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b1, 8'h00);
    chk("reg_q_after_err", regq_v[0],
        {32'h0A9B_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF22_FF44, 32'hDEAD_BEEF, 32'h0});
    xfer(0, 1'b0, 12'h01C, 32'h0, 4'h0, 32'h0A9B_0001, 1'b0, 8'h00);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 32'h0, 1'b1, 8'h00);
    xfer(0, 1'b0, 12'h006, 32'h0, 4'h0, 32'h0, 1'b1, 8'h00);

    // Three wait states.
    xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, 32'h0, 1'b0, 8'h00);
    xfer(1, 1'b1, 12'h010, 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0, 8'h10);
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, 32'hA5A5_0F0F, 1'b0, 8'h00);

    // Five wait states: a good write, then an abort, then a reset mid-transfer.
    xfer(2, 1'b1, 12'h008, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 8'h04);
    sel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h5555_5555; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1 sel = 3'b000; penable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge pclk); #1;
      chk("abort_reg_wr", 256'(regwr_v[2]), 256'h0);
    end
    chk("abort_reg_q", regq_v[2], {32'h0A9B_0001, 128'h0, 32'h1234_5678, 64'h0});

    sel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h7777_7777; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b1; sel = 3'b000; penable = 1'b0;
    @(posedge pclk); #1 preset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge pclk); #1;
      chk("rst_abort_reg_wr", 256'(regwr_v[2]), 256'h0);
      chk("rst_abort_pready", 256'(pready_v[2]), 256'h0);
    end
    chk("rst_abort_reg_q", regq_v[2], ID_ONLY);
    xfer(2, 1'b0, 12'h008, 32'h0, 4'h0, 32'h0, 1'b0, 8'h00);
    xfer(2, 1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b0, 8'h00);

    repeat (3) @(posedge pclk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d responses still expected", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
